// File: rtl/echo_request_demux_pkg.sv
`default_nettype none
// ============================================================================
// Module      : echo_request_demux_pkg
// Description : Shared header layout, state encodings and defaults for the
//               Echo request demux and its message framer.
// Revision    : 1.0 - initial release
// ============================================================================
package echo_request_demux_pkg;

    localparam int HDR_ID_MSB  = 31;
    localparam int HDR_ID_LSB  = 16;
    localparam int HDR_LEN_MSB = 15;
    localparam int HDR_LEN_LSB = 0;

    localparam int c_ID_WIDTH  = HDR_ID_MSB - HDR_ID_LSB + 1;
    localparam int c_LEN_WIDTH = HDR_LEN_MSB - HDR_LEN_LSB + 1;

    localparam logic [c_ID_WIDTH-1:0] ECHO_METHOD_ID_DEFAULT = 16'h0000;

    localparam logic [1:0] c_ST_HDR   = 2'd0;
    localparam logic [1:0] c_ST_PAY   = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;
    localparam logic [1:0] c_ST_DISP  = 2'd3;

    function automatic logic [c_ID_WIDTH-1:0] hdr_id(input logic [31:0] word);
        return word[HDR_ID_MSB:HDR_ID_LSB];
    endfunction

    function automatic logic [c_LEN_WIDTH-1:0] hdr_len(input logic [31:0] word);
        return word[HDR_LEN_MSB:HDR_LEN_LSB];
    endfunction

endpackage
`default_nettype wire

// File: rtl/echo_request_demux_framer.sv
`default_nettype none
// ============================================================================
// Module      : portal_msg_framer
// Description : Splits a header+payload word stream into messages; payloads of
//               rejected headers are drained so the stream never stalls.
// Revision    : 1.0 - initial release
// ============================================================================
module portal_msg_framer
    import echo_request_demux_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_in_ena,
    input  logic [31:0]            i_in_data,
    output logic                   o_in_rdy,
    input  logic                   i_hdr_accept,
    output logic [c_ID_WIDTH-1:0]  o_hdr_id,
    output logic [c_LEN_WIDTH-1:0] o_hdr_len,
    output logic                   o_hdr_err,
    output logic                   o_msg_ena,
    output logic [c_ID_WIDTH-1:0]  o_msg_id,
    output logic [31:0]            o_msg_data,
    output logic                   o_msg_last,
    input  logic                   i_msg_rdy
);

    localparam logic [c_LEN_WIDTH-1:0] c_LEN_ONE = 1;

    logic [1:0]             r_state;
    logic [c_LEN_WIDTH-1:0] r_cnt;
    logic [c_ID_WIDTH-1:0]  r_id;
    logic                   w_take;

    assign o_in_rdy   = (r_state == c_ST_PAY) ? i_msg_rdy : 1'b1;
    assign w_take     = i_in_ena & o_in_rdy;
    assign o_hdr_id   = hdr_id(i_in_data);
    assign o_hdr_len  = hdr_len(i_in_data);
    // A zero-length header is rejected whatever its id; nothing follows it.
    assign o_hdr_err  = w_take && (r_state == c_ST_HDR) &&
                        ((o_hdr_len == '0) || !i_hdr_accept);
    assign o_msg_ena  = w_take && (r_state == c_ST_PAY);
    assign o_msg_id   = r_id;
    assign o_msg_data = i_in_data;
    assign o_msg_last = (r_cnt == c_LEN_ONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_HDR;
            r_cnt   <= '0;
            r_id    <= '0;
        end else if (w_take) begin
            case (r_state)
                c_ST_HDR: begin
                    if (o_hdr_len != '0) begin
                        r_cnt   <= o_hdr_len;
                        r_id    <= o_hdr_id;
                        r_state <= i_hdr_accept ? c_ST_PAY : c_ST_DRAIN;
                    end
                end
                c_ST_PAY, c_ST_DRAIN: begin
                    r_cnt <= r_cnt - c_LEN_ONE;
                    if (r_cnt == c_LEN_ONE) begin
                        r_state <= c_ST_HDR;
                    end
                end
                default: r_state <= c_ST_HDR;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/echo_request_demux.sv
`default_nettype none
// ============================================================================
// Module      : echo_request_demux
// Description : Parses host request messages and dispatches echoReq calls into
//               Echo, counting rejected messages and dispatched requests.
// Revision    : 1.0 - initial release
// ============================================================================
module echo_request_demux
    import echo_request_demux_pkg::*;
#(
    parameter logic [c_ID_WIDTH-1:0] ECHO_METHOD_ID = ECHO_METHOD_ID_DEFAULT,
    parameter int                    ERR_CNT_WIDTH  = 16
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic                     in__ENA,
    input  logic [31:0]              in_v,
    output logic                     in__RDY,
    output logic                     echoReq__ENA,
    output logic [31:0]              echoReq_v,
    input  logic                     echoReq__RDY,
    output logic [ERR_CNT_WIDTH-1:0] errCount,
    output logic [31:0]              reqCount
);

    localparam logic [ERR_CNT_WIDTH-1:0] c_ERR_ONE = 1;
    localparam logic [c_LEN_WIDTH-1:0]   c_LEN_ONE = 1;

    logic                     r_disp;
    logic [31:0]              r_data;
    logic [ERR_CNT_WIDTH-1:0] r_err_count;
    logic [31:0]              r_req_count;

    logic                     w_frm_rdy;
    logic                     w_hdr_accept;
    logic [c_ID_WIDTH-1:0]    w_hdr_id;
    logic [c_LEN_WIDTH-1:0]   w_hdr_len;
    logic                     w_hdr_err;
    logic                     w_msg_ena;
    logic [c_ID_WIDTH-1:0]    w_msg_id;
    logic [31:0]              w_msg_data;
    logic                     w_msg_last;
    logic                     w_msg_rdy;
    logic                     w_capture;

    assign w_hdr_accept = (w_hdr_id == ECHO_METHOD_ID) && (w_hdr_len == c_LEN_ONE);
    // The framer is already back in header state while a call is pending,
    // so the next header can be taken in the cycle the call fires.
    assign w_msg_rdy    = !r_disp || echoReq__RDY;
    assign in__RDY      = !nRST && (r_disp ? echoReq__RDY : w_frm_rdy);
    assign echoReq__ENA = !nRST && r_disp && echoReq__RDY;
    assign echoReq_v    = r_disp ? r_data : 32'd0;
    assign errCount     = r_err_count;
    assign reqCount     = r_req_count;
    assign w_capture    = w_msg_ena && w_msg_last && (w_msg_id == ECHO_METHOD_ID);

    portal_msg_framer u_framer (
        .clk          (CLK),
        .rst          (nRST),
        .i_in_ena     (in__ENA & in__RDY),
        .i_in_data    (in_v),
        .o_in_rdy     (w_frm_rdy),
        .i_hdr_accept (w_hdr_accept),
        .o_hdr_id     (w_hdr_id),
        .o_hdr_len    (w_hdr_len),
        .o_hdr_err    (w_hdr_err),
        .o_msg_ena    (w_msg_ena),
        .o_msg_id     (w_msg_id),
        .o_msg_data   (w_msg_data),
        .o_msg_last   (w_msg_last),
        .i_msg_rdy    (w_msg_rdy)
    );

    always_ff @(posedge CLK) begin
        if (nRST) begin
            r_disp      <= 1'b0;
            r_data      <= '0;
            r_err_count <= '0;
            r_req_count <= '0;
        end else begin
            if (w_capture) begin
                r_disp <= 1'b1;
                r_data <= w_msg_data;
            end else if (echoReq__ENA) begin
                r_disp <= 1'b0;
            end
            if (echoReq__ENA) begin
                r_req_count <= r_req_count + 32'd1;
            end
            if (w_hdr_err && (r_err_count != '1)) begin
                r_err_count <= r_err_count + c_ERR_ONE;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_echo_request_demux.sv
`default_nettype none
// ============================================================================
// Module      : tb_echo_request_demux
// Description : Directed self-checking bench for echo_request_demux.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_echo_request_demux;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        in__ENA;
    logic [31:0] in_v;
    logic        in__RDY;
    logic        echoReq__ENA;
    logic [31:0] echoReq_v;
    logic        echoReq__RDY;
    logic [15:0] errCount;
    logic [31:0] reqCount;

    int n_run  = 0;
    int n_fail = 0;

    logic [31:0] b2b_data [4] = '{32'hA0A0A0A0, 32'hB1B1B1B1, 32'hC2C2C2C2, 32'hD3D3D3D3};

    echo_request_demux dut (
        .CLK          (CLK),
        .nRST         (nRST),
        .in__ENA      (in__ENA),
        .in_v         (in_v),
        .in__RDY      (in__RDY),
        .echoReq__ENA (echoReq__ENA),
        .echoReq_v    (echoReq_v),
        .echoReq__RDY (echoReq__RDY),
        .errCount     (errCount),
        .reqCount     (reqCount)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        nRST    = 1'b1;
        in__ENA = 1'b0;
        tick();
        nRST    = 1'b0;
    endtask

    initial begin
        nRST = 1'b1; in__ENA = 1'b0; in_v = '0; echoReq__RDY = 1'b1;
        tick();
        #1;
        check("rst_in_rdy", in__RDY, 0);
        check("rst_ena", echoReq__ENA, 0);
        check("rst_err", errCount, 0);
        check("rst_req", reqCount, 0);
        check("rst_v", echoReq_v, 0);
        nRST = 1'b0;
        #1;
        check("idle_in_rdy", in__RDY, 1);

        // Basic echo
        in__ENA = 1'b1; in_v = 32'h00000001; tick();
        in_v = 32'hDEADBEEF; #1;
        check("basic_no_early_ena", echoReq__ENA, 0);
        tick();
        in__ENA = 1'b0; #1;
        check("basic_ena", echoReq__ENA, 1);
        check("basic_v", echoReq_v, 32'hDEADBEEF);
        tick();
        check("basic_ena_drop", echoReq__ENA, 0);
        check("basic_req", reqCount, 1);
        check("basic_err", errCount, 0);
        check("basic_v_idle", echoReq_v, 0);

        // Backpressure, including ignored words offered while not ready
        echoReq__RDY = 1'b0;
        in__ENA = 1'b1; in_v = 32'h00000001; tick();
        in_v = 32'hDEADBEEF; tick();
        for (int k = 0; k < 5; k++) begin
            in__ENA = (k >= 3);
            in_v    = 32'h00000001;
            #1;
            check("bp_in_rdy", in__RDY, 0);
            check("bp_v_hold", echoReq_v, 32'hDEADBEEF);
            check("bp_no_ena", echoReq__ENA, 0);
            tick();
        end
        echoReq__RDY = 1'b1; in__ENA = 1'b1; in_v = 32'h00000001; #1;
        check("bp_ena", echoReq__ENA, 1);
        check("bp_in_rdy_rise", in__RDY, 1);
        check("bp_v", echoReq_v, 32'hDEADBEEF);
        tick();
        check("bp_req", reqCount, 2);
        in_v = 32'hCAFEF00D; tick();
        in__ENA = 1'b0; #1;
        check("bp_next_ena", echoReq__ENA, 1);
        check("bp_next_v", echoReq_v, 32'hCAFEF00D);
        tick();
        check("bp_req2", reqCount, 3);
        check("bp_err", errCount, 0);

        // Unknown id drained, then a valid echo
        do_reset();
        in__ENA = 1'b1; in_v = 32'h00050003; #1;
        check("unk_in_rdy", in__RDY, 1);
        tick();
        for (int j = 0; j < 3; j++) begin
            in_v = 32'hAAAA0000 + j;
            #1;
            check("unk_drain_rdy", in__RDY, 1);
            check("unk_drain_no_ena", echoReq__ENA, 0);
            tick();
        end
        in_v = 32'h00000001; #1;
        check("unk_err", errCount, 1);
        tick();
        in_v = 32'h12345678; tick();
        in__ENA = 1'b0; #1;
        check("unk_ena", echoReq__ENA, 1);
        check("unk_v", echoReq_v, 32'h12345678);
        tick();
        check("unk_req", reqCount, 1);
        check("unk_err_final", errCount, 1);
        check("unk_ena_drop", echoReq__ENA, 0);

        // Malformed lengths
        do_reset();
        in__ENA = 1'b1; in_v = 32'h00000000; tick();
        check("mal_err_zero", errCount, 1);
        in_v = 32'h00000002; tick();
        in_v = 32'h11111111; #1;
        check("mal_no_ena0", echoReq__ENA, 0);
        tick();
        in_v = 32'h22222222; #1;
        check("mal_no_ena1", echoReq__ENA, 0);
        tick();
        in__ENA = 1'b0; #1;
        check("mal_err", errCount, 2);
        check("mal_no_ena2", echoReq__ENA, 0);
        check("mal_req", reqCount, 0);
        in__ENA = 1'b1; in_v = 32'h00000001; tick();
        in_v = 32'h0BADCAFE; tick();
        in__ENA = 1'b0; #1;
        check("mal_recover_ena", echoReq__ENA, 1);
        check("mal_recover_v", echoReq_v, 32'h0BADCAFE);
        tick();

        // Back-to-back streaming
        do_reset();
        for (int i = 0; i < 9; i++) begin
            in__ENA = (i < 8);
            in_v    = (i % 2 == 0) ? 32'h00000001 : b2b_data[i / 2];
            #1;
            check("b2b_ena", echoReq__ENA, (i >= 2) && (i % 2 == 0));
            check("b2b_in_rdy", in__RDY, 1);
            if ((i >= 2) && (i % 2 == 0)) begin
                check("b2b_v", echoReq_v, b2b_data[i / 2 - 1]);
            end
            tick();
        end
        check("b2b_req", reqCount, 4);

        // Reset between header and payload
        in__ENA = 1'b1; in_v = 32'h00000000; tick();
        in_v = 32'h00000001; tick();
        nRST = 1'b1; in__ENA = 1'b0; #1;
        check("mid_rst_in_rdy", in__RDY, 0);
        check("mid_rst_ena", echoReq__ENA, 0);
        tick();
        nRST = 1'b0; #1;
        check("mid_rst_err", errCount, 0);
        check("mid_rst_req", reqCount, 0);
        in__ENA = 1'b1; in_v = 32'h00000001; tick();
        in_v = 32'h00000055; #1;
        check("mid_hdr_not_payload", echoReq__ENA, 0);
        tick();
        in__ENA = 1'b0; #1;
        check("mid_ena", echoReq__ENA, 1);
        check("mid_v", echoReq_v, 32'h00000055);
        tick();

        // Error counter saturation
        do_reset();
        in__ENA = 1'b1; in_v = 32'h00000000;
        repeat (65534) tick();
        check("sat_fffe", errCount, 32'h0000FFFE);
        tick();
        check("sat_ffff", errCount, 32'h0000FFFF);
        repeat (2) tick();
        check("sat_hold", errCount, 32'h0000FFFF);
        in__ENA = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
